// File: rtl/knn_pkg.sv
// Shared types and constants for the kNN stream front end.
//   knn_state_e : front-end FSM states
//   KNN_*       : default word width, result count and points per frame
//   point_base  : low bit index of point i inside the packed core bus
package knn_pkg;

  localparam int unsigned KNN_W = 32;
  localparam int unsigned KNN_K = 2;
  localparam int unsigned KNN_N = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_OUT    = 2'd3
  } knn_state_e;

  // Points fill downward from just below the query; the last point lands at bit 0.
  function automatic int unsigned point_base(input int unsigned idx,
                                             input int unsigned n,
                                             input int unsigned w);
    return (n - 1 - idx) * w;
  endfunction

endpackage

// File: rtl/knn_stream_frontend_if.sv
// Input beat stream and result stream of the kNN front end.
//   in_valid/in_ready/in_sop/in_data : query/point beats (sop marks the query)
//   out_valid/out_ready/out_data     : captured K-word result
//   master : traffic source / result sink
//   slave  : the front end
interface knn_stream_frontend_if
  import knn_pkg::*;
#(
  parameter int unsigned W = KNN_W,
  parameter int unsigned K = KNN_K
) ();

  logic           in_valid;
  logic           in_ready;
  logic           in_sop;
  logic [W-1:0]   in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W*K-1:0] out_data;

  modport master (
    output in_valid, in_sop, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_sop, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/knn_stream_frontend.sv
// Sequential front end for the combinational kNN core.
// Collects one query and N points, presents them packed to the core, waits
// SETTLE_CYC cycles, then captures the core result for a valid/ready output.
//   clk, rst_n  : clock, async active-low reset
//   strm        : input beat stream and result stream (slave side)
//   knn_p_input : registered packed bus {query, point0 .. pointN-1} to the core
//   knn_o       : combinational result from the core
//   busy        : high whenever the FSM is not idle
//   frame_err   : one-cycle pulse on an orphan point or a mid-frame restart
module knn_stream_frontend
  import knn_pkg::*;
#(
  parameter int unsigned W          = KNN_W,
  parameter int unsigned K          = KNN_K,
  parameter int unsigned N          = KNN_N,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  knn_stream_frontend_if.slave strm,
  output logic [(N+1)*W-1:0]   knn_p_input,
  input  logic [W*K-1:0]       knn_o,
  output logic                 busy,
  output logic                 frame_err
);

  localparam int unsigned BUS_W = (N + 1) * W;
  localparam int unsigned RES_W = W * K;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SET_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

  localparam logic [CNT_W-1:0] LAST_PT    = CNT_W'(N - 1);
  localparam logic [SET_W-1:0] SETTLE_LIM = SET_W'(SETTLE_CYC);

  knn_state_e        state_q, state_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [SET_W-1:0]  scnt_q, scnt_d;
  logic [BUS_W-1:0]  bus_q, bus_d;
  logic [RES_W-1:0]  res_q, res_d;
  logic              ovalid_q, ovalid_d;
  logic              ferr_q, ferr_d;
  logic              iready_q, iready_d;
  logic              busy_q, busy_d;
  logic              accept;

  assign accept = strm.in_valid && iready_q;

  // Next-state, packing and capture logic.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    scnt_d   = scnt_q;
    bus_d    = bus_q;
    res_d    = res_q;
    ovalid_d = ovalid_q;
    ferr_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (strm.in_sop) begin
            bus_d[BUS_W-1 -: W] = strm.in_data;
            wcnt_d              = '0;
            state_d             = ST_LOAD;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        if (accept) begin
          if (strm.in_sop) begin
            // Restart: stale points are overwritten as the new frame fills.
            bus_d[BUS_W-1 -: W] = strm.in_data;
            wcnt_d              = '0;
            ferr_d              = 1'b1;
          end else begin
            for (int unsigned i = 0; i < N; i++) begin
              if (wcnt_q == CNT_W'(i)) begin
                bus_d[point_base(i, N, W) +: W] = strm.in_data;
              end
            end
            if (wcnt_q == LAST_PT) begin
              wcnt_d  = '0;
              scnt_d  = '0;
              state_d = ST_SETTLE;
            end else begin
              wcnt_d = wcnt_q + CNT_W'(1);
            end
          end
        end
      end

      ST_SETTLE: begin
        if (scnt_q == SETTLE_LIM) begin
          res_d    = knn_o;
          ovalid_d = 1'b1;
          state_d  = ST_OUT;
        end else begin
          scnt_d = scnt_q + SET_W'(1);
        end
      end

      ST_OUT: begin
        if (strm.out_ready) begin
          ovalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Ready/busy are registered from the upcoming state so they track it exactly.
    iready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    busy_d   = (state_d != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wcnt_q   <= '0;
      scnt_q   <= '0;
      bus_q    <= '0;
      res_q    <= '0;
      ovalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      iready_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      scnt_q   <= scnt_d;
      bus_q    <= bus_d;
      res_q    <= res_d;
      ovalid_q <= ovalid_d;
      ferr_q   <= ferr_d;
      iready_q <= iready_d;
      busy_q   <= busy_d;
    end
  end

  assign strm.in_ready  = iready_q;
  assign strm.out_valid = ovalid_q;
  assign strm.out_data  = res_q;
  assign knn_p_input    = bus_q;
  assign busy           = busy_q;
  assign frame_err      = ferr_q;

endmodule

// File: tb/tb_knn_stream_frontend.sv
// Bench for knn_stream_frontend: two instances (SETTLE_CYC 1 and 3) share one
// stimulus driver; the unselected one is held in reset. Core stub returns the
// low 64 bits of the packed bus. Results go through a scoreboard queue.
module tb_knn_stream_frontend;
  import knn_pkg::*;

  localparam int unsigned W     = 32;
  localparam int unsigned K     = 2;
  localparam int unsigned N     = 4;
  localparam int unsigned BUS_W = (N + 1) * W;
  localparam int unsigned RES_W = W * K;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             sel;
  logic             in_valid, in_sop, out_ready;
  logic [W-1:0]     in_data;

  logic             rst1_n, rst3_n;
  logic [BUS_W-1:0] kp1, kp3, kp;
  logic [RES_W-1:0] ko1, ko3;
  logic             busy1, busy3, fe1, fe3, busy, fe;
  logic             in_ready, out_valid;
  logic [RES_W-1:0] out_data;

  knn_stream_frontend_if #(.W(W), .K(K)) if1 ();
  knn_stream_frontend_if #(.W(W), .K(K)) if3 ();

  assign rst1_n = rst_n & ~sel;
  assign rst3_n = rst_n & sel;
  assign ko1 = kp1[RES_W-1:0];
  assign ko3 = kp3[RES_W-1:0];

  assign if1.in_valid  = in_valid;
  assign if1.in_sop    = in_sop;
  assign if1.in_data   = in_data;
  assign if1.out_ready = out_ready;
  assign if3.in_valid  = in_valid;
  assign if3.in_sop    = in_sop;
  assign if3.in_data   = in_data;
  assign if3.out_ready = out_ready;

  assign in_ready  = sel ? if3.in_ready  : if1.in_ready;
  assign out_valid = sel ? if3.out_valid : if1.out_valid;
  assign out_data  = sel ? if3.out_data  : if1.out_data;
  assign kp        = sel ? kp3 : kp1;
  assign busy      = sel ? busy3 : busy1;
  assign fe        = sel ? fe3 : fe1;

  knn_stream_frontend #(.W(W), .K(K), .N(N), .SETTLE_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .strm(if1), .knn_p_input(kp1),
    .knn_o(ko1), .busy(busy1), .frame_err(fe1)
  );

  knn_stream_frontend #(.W(W), .K(K), .N(N), .SETTLE_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .strm(if3), .knn_p_input(kp3),
    .knn_o(ko3), .busy(busy3), .frame_err(fe3)
  );

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  logic [RES_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [BUS_W-1:0] act,
                     input logic [BUS_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Result monitor: every handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected none", out_data);
      end else begin
        chk("out_data", BUS_W'(out_data), BUS_W'(exp_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (fe) fe_cnt <= fe_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Drive one beat starting at posedge+1; returns at acceptance edge +1.
  task automatic send(input logic sop, input logic [W-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_sop   = sop;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] q, a, b, c, d);
    send(1'b1, q);
    send(1'b0, a);
    send(1'b0, b);
    send(1'b0, c);
    send(1'b0, d);
  endtask

  // Counts cycles from the last acceptance edge until out_valid is seen.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
  endtask

  // Waits for the scoreboard to drain, then steps past the handshake edge.
  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      in_valid  = 1'($urandom);
      in_sop    = 1'($urandom);
      in_data   = W'($urandom);
      out_ready = 1'($urandom);
    end
    @(negedge clk);
    chk("rst_in_ready", BUS_W'(in_ready), BUS_W'(1));
    chk("rst_out_valid", BUS_W'(out_valid), BUS_W'(0));
    chk("rst_busy", BUS_W'(busy), BUS_W'(0));
    chk("rst_knn_p_input", kp, BUS_W'(0));
    chk("rst_out_data", BUS_W'(out_data), BUS_W'(0));
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, fe0, hits, settle;
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    sel       = 1'b0;

    for (int s = 0; s < 2; s++) begin
      sel    = 1'(s);
      settle = (s == 0) ? 1 : 3;
      do_reset();

      // Normal frame: query 10, points 3,12,40,9.
      exp_q.push_back({32'd40, 32'd9});
      send_frame(32'd10, 32'd3, 32'd12, 32'd40, 32'd9);
      wait_valid(lat);
      chk("latency", BUS_W'(lat), BUS_W'(settle + 2));
      drain();
      chk("packed_bus", kp, {32'd10, 32'd3, 32'd12, 32'd40, 32'd9});

      if (s == 0) begin
        // Backpressure: result held while out_ready is low.
        out_ready = 1'b0;
        exp_q.push_back({32'd3, 32'd4});
        send_frame(32'd100, 32'd1, 32'd2, 32'd3, 32'd4);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
          chk("bp_out_data", BUS_W'(out_data), BUS_W'({32'd3, 32'd4}));
          chk("bp_in_ready", BUS_W'(in_ready), BUS_W'(0));
          chk("bp_busy", BUS_W'(busy), BUS_W'(1));
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        chk("bp_done_valid", BUS_W'(out_valid), BUS_W'(0));
        chk("bp_done_ready", BUS_W'(in_ready), BUS_W'(1));
        chk("bp_done_busy", BUS_W'(busy), BUS_W'(0));

        // Restart mid-frame.
        fe0 = fe_cnt;
        exp_q.push_back({32'd10, 32'd11});
        send(1'b1, 32'd1);
        send(1'b0, 32'd2);
        send(1'b0, 32'd3);
        send_frame(32'd7, 32'd8, 32'd9, 32'd10, 32'd11);
        wait_valid(lat);
        drain();
        repeat (4) @(posedge clk);
        #1;
        chk("restart_frame_err", BUS_W'(fe_cnt - fe0), BUS_W'(1));
        chk("restart_bus", kp, {32'd7, 32'd8, 32'd9, 32'd10, 32'd11});
        chk("restart_single_result", BUS_W'(out_valid), BUS_W'(0));

        // Orphan point in IDLE.
        fe0 = fe_cnt;
        send(1'b0, 32'd5);
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("orphan_frame_err", BUS_W'(fe_cnt - fe0), BUS_W'(1));
        chk("orphan_busy", BUS_W'(busy), BUS_W'(0));
        chk("orphan_in_ready", BUS_W'(in_ready), BUS_W'(1));
        chk("orphan_bus", kp, {32'd7, 32'd8, 32'd9, 32'd10, 32'd11});
      end else begin
        // Reset on settle cycle 1 drops the pending result.
        send_frame(32'd20, 32'd1, 32'd2, 32'd3, 32'd4);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("settle_rst_bus", kp, BUS_W'(0));
        hits = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (out_valid) hits++;
        end
        chk("settle_rst_no_valid", BUS_W'(hits), BUS_W'(0));
        chk("settle_rst_in_ready", BUS_W'(in_ready), BUS_W'(1));
        @(posedge clk);
        #1;
        exp_q.push_back({32'd8, 32'd9});
        send_frame(32'd50, 32'd6, 32'd7, 32'd8, 32'd9);
        wait_valid(lat);
        chk("post_rst_latency", BUS_W'(lat), BUS_W'(5));
        drain();
        chk("post_rst_bus", kp, {32'd50, 32'd6, 32'd7, 32'd8, 32'd9});
      end
    end

    chk("scoreboard_empty", BUS_W'(exp_q.size()), BUS_W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
